// File: rtl/joypad_matrix.sv
// Joypad board-side front end: 2-flop sync, per-key debounce, active-low nibble mux, falling-edge IRQ.
// Optional macro JOYPAD_SOCD_EN masks opposing direction pairs (both pressed reads as both released).
module joypad_matrix #(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] buttons_raw,
  input  logic [1:0] button_sel,
  output logic [3:0] button_data,
  output logic       int_req,
  input  logic       int_ack
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync_a;
  logic [7:0]       synced;
  logic [7:0]       stable;
  logic [CNT_W-1:0] cnt [8];
  logic [3:0]       dir;
  logic [3:0]       act;
  logic [3:0]       eff_dir;
  logic [3:0]       next_data;
  logic [3:0]       prev_data;
  logic [3:0]       fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= '0;
      synced <= '0;
    end else begin
      sync_a <= buttons_raw;
      synced <= sync_a;
    end
  end

  // Each key debounces independently; any sample agreeing with stable restarts its count.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (synced[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= synced[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    dir = stable[3:0];
    act = stable[7:4];
`ifdef JOYPAD_SOCD_EN
    eff_dir = dir & ~{{2{dir[2] & dir[3]}}, {2{dir[0] & dir[1]}}};
`else
    eff_dir = dir;
`endif
    next_data = ~(({4{~button_sel[0]}} & eff_dir) | ({4{~button_sel[1]}} & act));
  end

  assign fall = prev_data & ~button_data;

  // Select changes that expose a held key also produce a falling edge here.
  always_ff @(posedge clock) begin
    if (reset) begin
      button_data <= '1;
      prev_data   <= '1;
      int_req     <= 1'b0;
    end else begin
      button_data <= next_data;
      prev_data   <= button_data;
      if (|fall)        int_req <= 1'b1;
      else if (int_ack) int_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_joypad_matrix.sv
// Directed self-checking bench for joypad_matrix with a short debounce window.
module tb_joypad_matrix;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] buttons_raw;
  logic [1:0] button_sel;
  logic [3:0] button_data;
  logic       int_req;
  logic       int_ack;

  int checks   = 0;
  int failures = 0;

  joypad_matrix #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clock(clock),
    .reset(reset),
    .buttons_raw(buttons_raw),
    .button_sel(button_sel),
    .button_data(button_data),
    .int_req(int_req),
    .int_ack(int_ack)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; buttons_raw = 8'h00; button_sel = 2'b11; int_ack = 1'b0;
    step(2);
    chk("reset_data", button_data, 4'hF);
    chk("reset_int", {3'b0, int_req}, 4'h0);
    reset = 1'b0;
    step(1);

    // A held with nothing selected, then action group selected
    buttons_raw = 8'h10;
    step(10);
    chk("sel11_data", button_data, 4'hF);
    chk("sel11_int", {3'b0, int_req}, 4'h0);
    button_sel = 2'b01;
    step(1);
    chk("sel01_data", button_data, 4'hE);
    step(1);
    chk("sel01_int", {3'b0, int_req}, 4'h1);
    ack_pulse();
    chk("ack_clears", {3'b0, int_req}, 4'h0);
    buttons_raw = 8'h00;
    step(10);
    chk("release_a_data", button_data, 4'hF);
    chk("release_a_int", {3'b0, int_req}, 4'h0);

    // Short glitch on Right must be filtered
    button_sel = 2'b10;
    buttons_raw = 8'h01;
    step(3);
    buttons_raw = 8'h00;
    step(10);
    chk("glitch_data", button_data, 4'hF);
    chk("glitch_int", {3'b0, int_req}, 4'h0);

    // Clean press latency: 2 + 4 + 1
    buttons_raw = 8'h01;
    step(6);
    chk("lat6_data", button_data, 4'hF);
    step(1);
    chk("lat7_data", button_data, 4'hE);
    step(1);
    chk("right_int", {3'b0, int_req}, 4'h1);
    ack_pulse();
    chk("right_ack", {3'b0, int_req}, 4'h0);
    buttons_raw = 8'h00;
    step(10);
    chk("right_rel", button_data, 4'hF);

    // Ack coincident with a new falling edge: set wins
    buttons_raw = 8'h08;
    step(7);
    chk("down_data", button_data, 4'h7);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    chk("set_wins", {3'b0, int_req}, 4'h1);
    ack_pulse();
    chk("down_ack", {3'b0, int_req}, 4'h0);
    buttons_raw = 8'h00;
    step(10);

    // Both groups selected: Up + Start
    button_sel = 2'b00;
    buttons_raw = 8'h84;
    step(10);
    chk("both_data", button_data, 4'h3);
    ack_pulse();
    chk("both_ack", {3'b0, int_req}, 4'h0);
    buttons_raw = 8'h80;
    step(10);
    chk("up_rel_data", button_data, 4'h7);
    chk("up_rel_int", {3'b0, int_req}, 4'h0);
    ack_pulse();
    chk("idle_ack", {3'b0, int_req}, 4'h0);
    buttons_raw = 8'h00;
    step(10);

    // Opposing directions
    button_sel = 2'b10;
    buttons_raw = 8'h03;
    step(10);
`ifdef JOYPAD_SOCD_EN
    chk("lr_data", button_data, 4'hF);
    chk("lr_int", {3'b0, int_req}, 4'h0);
`else
    chk("lr_data", button_data, 4'hC);
    chk("lr_int", {3'b0, int_req}, 4'h1);
`endif
    ack_pulse();
    buttons_raw = 8'h00;
    step(10);
    ack_pulse();
    chk("pre6_int", {3'b0, int_req}, 4'h0);

    // Reset mid-debounce with int_req pending
    buttons_raw = 8'h01;
    step(10);
    chk("pre6_data", button_data, 4'hE);
    chk("pre6_irq", {3'b0, int_req}, 4'h1);
    buttons_raw = 8'h02;
    step(4);
    reset = 1'b1;
    step(1);
    chk("rst_mid_data", button_data, 4'hF);
    chk("rst_mid_int", {3'b0, int_req}, 4'h0);
    reset = 1'b0;
    step(6);
    chk("post_rst6", button_data, 4'hF);
    step(1);
    chk("post_rst7", button_data, 4'hD);
    step(1);
    chk("post_rst_int", {3'b0, int_req}, 4'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
